// File: rtl/msc16_pkg.sv
// Shared types and register map for the msc16 memory responder.
package msc16_pkg;

    typedef logic [15:0] word_t;

    // Byte offsets from the I/O window base
    localparam word_t IO_CTRL    = 16'h0000;
    localparam word_t IO_COUNT   = 16'h0002;
    localparam word_t IO_CMP     = 16'h0004;
    localparam word_t IO_STATUS  = 16'h0006;
    localparam word_t IO_SCRATCH = 16'h0008;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_AUTO   = 2;
    localparam int CTRL_PS_LO  = 4;
    localparam int CTRL_PS_HI  = 7;
    localparam word_t CTRL_MASK = 16'h00F7;

    localparam int STAT_MATCH = 0;
    localparam int STAT_PROT  = 1;

endpackage

// File: rtl/msc16_mem_resp_if.sv
// CPU memory port bundle between the msc16 core and its memory responder.
interface msc16_mem_resp_if;
    import msc16_pkg::*;

    logic  mem_en;
    logic  mem_we;
    word_t mem_addr;
    word_t mem_wdata;
    word_t mem_rdata;

    modport master (output mem_en, output mem_we, output mem_addr, output mem_wdata,
                    input mem_rdata);
    modport slave  (input mem_en, input mem_we, input mem_addr, input mem_wdata,
                    output mem_rdata);

endinterface

// File: rtl/msc16_timer.sv
// Prescaled timer with compare match, sticky status flags and registered irq.
module msc16_timer
    import msc16_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  ctrl_we,
    input  logic  count_we,
    input  logic  cmp_we,
    input  logic  status_we,
    input  word_t wdata,
    input  logic  prot_set,
    output word_t ctrl,
    output word_t count,
    output word_t cmp,
    output word_t status,
    output logic  irq
);

    logic [3:0]  ps;
    logic [15:0] psc;
    logic        tick;
    logic        hit;
    logic        match;
    logic        prot_err;

    assign ps     = ctrl[CTRL_PS_HI:CTRL_PS_LO];
    assign tick   = ctrl[CTRL_EN] && (psc == ((16'd1 << ps) - 16'd1));
    assign hit    = tick && (count == cmp);
    assign status = {14'd0, prot_err, match};

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl     <= '0;
            count    <= '0;
            cmp      <= 16'hFFFF;
            psc      <= '0;
            match    <= 1'b0;
            prot_err <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (ctrl_we)
                ctrl <= wdata & CTRL_MASK;

            // Disabled timer parks the prescaler so the first tick after enable is a full period
            if (!ctrl[CTRL_EN] || tick)
                psc <= '0;
            else
                psc <= psc + 16'd1;

            if (count_we)
                count <= wdata;
            else if (hit && ctrl[CTRL_AUTO])
                count <= '0;
            else if (tick)
                count <= count + 16'd1;

            if (cmp_we)
                cmp <= wdata;

            // Set has priority over write-1-to-clear
            if (hit)
                match <= 1'b1;
            else if (status_we && wdata[STAT_MATCH])
                match <= 1'b0;

            if (prot_set)
                prot_err <= 1'b1;
            else if (status_we && wdata[STAT_PROT])
                prot_err <= 1'b0;

            irq <= match & ctrl[CTRL_IRQ_EN];
        end
    end

endmodule

// File: rtl/msc16_mem_resp.sv
// msc16 memory responder: word RAM below IO_BASE, timer/scratch registers above.
// Optional build macro MSC16_ROM_PROTECT_EN write-protects RAM below ROM_TOP.
module msc16_mem_resp
    import msc16_pkg::*;
#(
    parameter int    ADDR_W  = 10,
    parameter word_t IO_BASE = 16'hFF00,
    parameter word_t ROM_TOP = 16'h0200
)(
    input  logic             clk,
    input  logic             rst,
    msc16_mem_resp_if.slave  bus,
    output logic             irq
);

`ifdef MSC16_ROM_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    word_t             ram [2**ADDR_W];
    logic              is_io;
    word_t             io_off;
    logic [ADDR_W-1:0] idx;
    logic              wr;
    logic              prot;
    logic              ram_we;
    word_t             io_rdata;
    word_t             ctrl, count, cmp, status;
    word_t             scratch;

    assign is_io  = bus.mem_addr >= IO_BASE;
    assign io_off = (bus.mem_addr - IO_BASE) & 16'hFFFE;
    assign idx    = bus.mem_addr[ADDR_W:1];
    assign wr     = bus.mem_en && bus.mem_we;
    assign prot   = PROT_EN && wr && !is_io && (bus.mem_addr < ROM_TOP);
    assign ram_we = wr && !is_io && !prot;

    always_comb begin
        io_rdata = '0;
        case (io_off)
            IO_CTRL:    io_rdata = ctrl;
            IO_COUNT:   io_rdata = count;
            IO_CMP:     io_rdata = cmp;
            IO_STATUS:  io_rdata = status;
            IO_SCRATCH: io_rdata = scratch;
            default:    io_rdata = '0;
        endcase
    end

    msc16_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .ctrl_we   (wr && is_io && (io_off == IO_CTRL)),
        .count_we  (wr && is_io && (io_off == IO_COUNT)),
        .cmp_we    (wr && is_io && (io_off == IO_CMP)),
        .status_we (wr && is_io && (io_off == IO_STATUS)),
        .wdata     (bus.mem_wdata),
        .prot_set  (prot),
        .ctrl      (ctrl),
        .count     (count),
        .cmp       (cmp),
        .status    (status),
        .irq       (irq)
    );

    always_ff @(posedge clk) begin
        if (ram_we)
            ram[idx] <= bus.mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            scratch <= '0;
        else if (wr && is_io && (io_off == IO_SCRATCH))
            scratch <= bus.mem_wdata;
    end

    // Write-first: a write returns its own data, except a suppressed ROM write returns the stored word
    always_ff @(posedge clk) begin
        if (rst)
            bus.mem_rdata <= '0;
        else if (bus.mem_en) begin
            if (wr && !prot)
                bus.mem_rdata <= bus.mem_wdata;
            else if (is_io)
                bus.mem_rdata <= io_rdata;
            else
                bus.mem_rdata <= ram[idx];
        end
    end

endmodule

// File: tb/tb_msc16_mem_resp.sv
// Directed bench for msc16_mem_resp: RAM, aliasing, I/O registers, timer, reset, ROM protect.
module tb_msc16_mem_resp;

    localparam logic [15:0] IOB = 16'hFF00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;
    int   checks = 0;
    int   errors = 0;

    msc16_mem_resp_if bus();

    msc16_mem_resp #(.ADDR_W(10), .IO_BASE(16'hFF00), .ROM_TOP(16'h0200)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .irq (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

    // One port access per cycle; called just after a rising edge, returns just after the next one
    task automatic op(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                      output logic [15:0] rd);
        bus.mem_en    = 1'b1;
        bus.mem_we    = we;
        bus.mem_addr  = addr;
        bus.mem_wdata = wd;
        @(posedge clk); #1;
        rd = bus.mem_rdata;
        bus.mem_en = 1'b0;
        bus.mem_we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        bus.mem_en = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
        rst = 1'b1;
        idle(3);
        checks++; if (bus.mem_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h want %h", bus.mem_rdata, 16'h0000); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        rst = 1'b0;
    endtask

    task automatic test_ram;
        logic [15:0] rd;
        op(1'b1, 16'h0010, 16'hBEEF, rd);
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL ram_write_first: got %h want %h", rd, 16'hBEEF); end
        op(1'b1, 16'h0020, 16'h5555, rd);
        bus.mem_en = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 16'h0010;
        #1;
        checks++; if (bus.mem_rdata !== 16'h5555) begin errors++; $display("FAIL ram_latency_early: got %h want %h", bus.mem_rdata, 16'h5555); end
        @(posedge clk); #1;
        checks++; if (bus.mem_rdata !== 16'hBEEF) begin errors++; $display("FAIL ram_read: got %h want %h", bus.mem_rdata, 16'hBEEF); end
        bus.mem_en = 1'b0;
        op(1'b0, 16'h0011, 16'h0000, rd);
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL ram_odd_addr: got %h want %h", rd, 16'hBEEF); end
        // Idle cycle with write strobe but no enable must change nothing
        bus.mem_en = 1'b0; bus.mem_we = 1'b1; bus.mem_addr = 16'h0010; bus.mem_wdata = 16'h0BAD;
        @(posedge clk); #1;
        bus.mem_we = 1'b0;
        checks++; if (bus.mem_rdata !== 16'hBEEF) begin errors++; $display("FAIL en0_hold: got %h want %h", bus.mem_rdata, 16'hBEEF); end
        op(1'b0, 16'h0010, 16'h0000, rd);
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL en0_nowrite: got %h want %h", rd, 16'hBEEF); end
        op(1'b1, 16'h0800, 16'h1234, rd);
        op(1'b0, 16'h0000, 16'h0000, rd);
        checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL ram_alias: got %h want %h", rd, 16'h1234); end
    endtask

    task automatic test_io_regs;
        logic [15:0] rd;
        op(1'b0, IOB + 16'h4, 16'h0000, rd);
        checks++; if (rd !== 16'hFFFF) begin errors++; $display("FAIL cmp_reset: got %h want %h", rd, 16'hFFFF); end
        op(1'b1, IOB + 16'h8, 16'hA5C3, rd);
        op(1'b0, IOB + 16'h8, 16'h0000, rd);
        checks++; if (rd !== 16'hA5C3) begin errors++; $display("FAIL scratch_rw: got %h want %h", rd, 16'hA5C3); end
        op(1'b1, IOB + 16'hA, 16'h7777, rd);
        op(1'b0, IOB + 16'hA, 16'h0000, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL unmapped_read: got %h want %h", rd, 16'h0000); end
        op(1'b1, IOB, 16'hFFF0, rd);
        op(1'b0, IOB, 16'h0000, rd);
        checks++; if (rd !== 16'h00F0) begin errors++; $display("FAIL ctrl_mask: got %h want %h", rd, 16'h00F0); end
        op(1'b1, IOB, 16'h0000, rd);
    endtask

    task automatic test_timer_match;
        logic [15:0] rd;
        op(1'b1, IOB + 16'h4, 16'h0003, rd);
        op(1'b1, IOB, 16'h0007, rd);
        idle(4);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_before: got %b want 0", irq); end
        op(1'b0, IOB + 16'h2, 16'h0000, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL count_reload: got %h want %h", rd, 16'h0000); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_lag: got %b want 1", irq); end
        op(1'b0, IOB + 16'h6, 16'h0000, rd);
        checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL status_match: got %h want %h", rd, 16'h0001); end
        op(1'b1, IOB + 16'h6, 16'h0001, rd);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold_w1c: got %b want 1", irq); end
        op(1'b0, IOB + 16'h6, 16'h0000, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL status_w1c: got %h want %h", rd, 16'h0000); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq); end
        op(1'b0, IOB + 16'h6, 16'h0000, rd);
        checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL status_rematch: got %h want %h", rd, 16'h0001); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] rd;
        bus.mem_en = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = IOB + 16'h8; bus.mem_wdata = 16'hAAAA;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.mem_en = 1'b0; bus.mem_we = 1'b0;
        checks++; if (bus.mem_rdata !== 16'h0000) begin errors++; $display("FAIL rstmid_rdata: got %h want %h", bus.mem_rdata, 16'h0000); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rstmid_irq: got %b want 0", irq); end
        op(1'b0, IOB + 16'h2, 16'h0000, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rstmid_count: got %h want %h", rd, 16'h0000); end
        op(1'b0, IOB + 16'h6, 16'h0000, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rstmid_status: got %h want %h", rd, 16'h0000); end
        op(1'b0, IOB + 16'h8, 16'h0000, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rstmid_scratch: got %h want %h", rd, 16'h0000); end
        op(1'b0, IOB, 16'h0000, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rstmid_ctrl: got %h want %h", rd, 16'h0000); end
        op(1'b0, IOB + 16'h4, 16'h0000, rd);
        checks++; if (rd !== 16'hFFFF) begin errors++; $display("FAIL rstmid_cmp: got %h want %h", rd, 16'hFFFF); end
        op(1'b0, 16'h0010, 16'h0000, rd);
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL rstmid_ram: got %h want %h", rd, 16'hBEEF); end
    endtask

    task automatic test_prescale;
        logic [15:0] rd;
        logic [15:0] vals [1:17];
        op(1'b1, IOB, 16'h0021, rd);
        for (int k = 1; k <= 11; k++) begin
            op(1'b0, IOB + 16'h2, 16'h0000, rd);
            vals[k] = rd;
        end
        checks++; if (vals[4] !== 16'h0000) begin errors++; $display("FAIL ps_c4: got %h want %h", vals[4], 16'h0000); end
        checks++; if (vals[5] !== 16'h0001) begin errors++; $display("FAIL ps_c5: got %h want %h", vals[5], 16'h0001); end
        checks++; if (vals[8] !== 16'h0001) begin errors++; $display("FAIL ps_c8: got %h want %h", vals[8], 16'h0001); end
        checks++; if (vals[9] !== 16'h0002) begin errors++; $display("FAIL ps_c9: got %h want %h", vals[9], 16'h0002); end
        op(1'b1, IOB + 16'h2, 16'h0050, rd);
        checks++; if (rd !== 16'h0050) begin errors++; $display("FAIL io_write_first: got %h want %h", rd, 16'h0050); end
        for (int k = 13; k <= 17; k++) begin
            op(1'b0, IOB + 16'h2, 16'h0000, rd);
            vals[k] = rd;
        end
        checks++; if (vals[13] !== 16'h0050) begin errors++; $display("FAIL ps_write_wins: got %h want %h", vals[13], 16'h0050); end
        checks++; if (vals[16] !== 16'h0050) begin errors++; $display("FAIL ps_c16: got %h want %h", vals[16], 16'h0050); end
        checks++; if (vals[17] !== 16'h0051) begin errors++; $display("FAIL ps_c17: got %h want %h", vals[17], 16'h0051); end
    endtask

    task automatic test_rom;
        logic [15:0] rd;
`ifdef MSC16_ROM_PROTECT_EN
        logic [15:0] prior;
        op(1'b0, 16'h0004, 16'h0000, prior);
        op(1'b1, 16'h0004, 16'hFFFF, rd);
        checks++; if (rd !== prior) begin errors++; $display("FAIL rom_wr_rdata: got %h want %h", rd, prior); end
        op(1'b0, 16'h0004, 16'h0000, rd);
        checks++; if (rd !== prior) begin errors++; $display("FAIL rom_unchanged: got %h want %h", rd, prior); end
        op(1'b0, IOB + 16'h6, 16'h0000, rd);
        checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL rom_prot_err: got %h want %h", rd, 16'h0002); end
        op(1'b1, IOB + 16'h6, 16'h0002, rd);
        op(1'b0, IOB + 16'h6, 16'h0000, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rom_w1c: got %h want %h", rd, 16'h0000); end
        op(1'b1, 16'h0400, 16'h7777, rd);
        op(1'b0, 16'h0400, 16'h0000, rd);
        checks++; if (rd !== 16'h7777) begin errors++; $display("FAIL rom_above_top: got %h want %h", rd, 16'h7777); end
`else
        op(1'b1, 16'h0004, 16'hFFFF, rd);
        op(1'b0, 16'h0004, 16'h0000, rd);
        checks++; if (rd !== 16'hFFFF) begin errors++; $display("FAIL low_ram_write: got %h want %h", rd, 16'hFFFF); end
        op(1'b0, IOB + 16'h6, 16'h0000, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL status_no_prot: got %h want %h", rd, 16'h0000); end
`endif
    endtask

    initial begin
        test_reset;
        test_ram;
        test_io_regs;
        test_timer_match;
        test_reset_mid;
        test_prescale;
        test_rom;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
